carry_select_subtractor_16bit_pipe: RTL and testbench



---
 rtl/carry_select_subtractor_16bit_pipe.sv | 120 ++++++++++++
 tb/tb_carry_select_subtractor_16bit_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/carry_select_subtractor_16bit_pipe.sv
// ---------------------------------------------------------------------------
// carry_select_subtractor_16bit_pipe : 4-stage pipelined a - b - bin, 4-bit carry-select slices
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module carry_select_subtractor_16bit_pipe #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int P1 = WIDTH - SLICE;
  localparam int P2 = WIDTH - 2 * SLICE;
  localparam int P3 = WIDTH - 3 * SLICE;

  // Both borrow-in candidates are formed up front; bit SLICE of each is its borrow-out.
  function automatic logic [SLICE:0] cs_slice(input logic [SLICE-1:0] x,
                                              input logic [SLICE-1:0] y,
                                              input logic             bi);
    logic [SLICE:0] d0;
    logic [SLICE:0] d1;
    d0 = {1'b0, x} - {1'b0, y};
    d1 = {1'b0, x} - {1'b0, y} - {{SLICE{1'b0}}, 1'b1};
    return bi ? d1 : d0;
  endfunction

  logic              r_v1, r_v2, r_v3, r_v4;
  logic [SLICE-1:0]  r_d1;
  logic [2*SLICE-1:0] r_d2;
  logic [3*SLICE-1:0] r_d3;
  logic [WIDTH-1:0]  r_d4;
  logic [P1-1:0]     r_a1, r_b1;
  logic [P2-1:0]     r_a2, r_b2;
  logic [P3-1:0]     r_a3, r_b3;
  logic              r_c1, r_c2, r_c3, r_c4;
  logic              r_sa1, r_sa2, r_sa3, r_sa4;
  logic              r_sb1, r_sb2, r_sb3, r_sb4;

  logic              w_adv1, w_adv2, w_adv3, w_adv4;
  logic [SLICE:0]    w_s0, w_s1, w_s2, w_s3;

  assign w_adv4 = !r_v4 || out_ready;
  assign w_adv3 = !r_v3 || w_adv4;
  assign w_adv2 = !r_v2 || w_adv3;
  assign w_adv1 = !r_v1 || w_adv2;

  assign w_s0 = cs_slice(a[SLICE-1:0], b[SLICE-1:0], bin);
  assign w_s1 = cs_slice(r_a1[SLICE-1:0], r_b1[SLICE-1:0], r_c1);
  assign w_s2 = cs_slice(r_a2[SLICE-1:0], r_b2[SLICE-1:0], r_c2);
  assign w_s3 = cs_slice(r_a3, r_b3, r_c3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0; r_v4 <= 1'b0;
      r_d1 <= '0;   r_d2 <= '0;   r_d3 <= '0;   r_d4 <= '0;
      r_a1 <= '0;   r_b1 <= '0;   r_a2 <= '0;   r_b2 <= '0;
      r_a3 <= '0;   r_b3 <= '0;
      r_c1 <= 1'b0; r_c2 <= 1'b0; r_c3 <= 1'b0; r_c4 <= 1'b0;
      r_sa1 <= 1'b0; r_sa2 <= 1'b0; r_sa3 <= 1'b0; r_sa4 <= 1'b0;
      r_sb1 <= 1'b0; r_sb2 <= 1'b0; r_sb3 <= 1'b0; r_sb4 <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1  <= in_valid;
        r_d1  <= w_s0[SLICE-1:0];
        r_c1  <= w_s0[SLICE];
        r_a1  <= a[WIDTH-1:SLICE];
        r_b1  <= b[WIDTH-1:SLICE];
        r_sa1 <= a[WIDTH-1];
        r_sb1 <= b[WIDTH-1];
      end
      if (w_adv2) begin
        r_v2  <= r_v1;
        r_d2  <= {w_s1[SLICE-1:0], r_d1};
        r_c2  <= w_s1[SLICE];
        r_a2  <= r_a1[P1-1:SLICE];
        r_b2  <= r_b1[P1-1:SLICE];
        r_sa2 <= r_sa1;
        r_sb2 <= r_sb1;
      end
      if (w_adv3) begin
        r_v3  <= r_v2;
        r_d3  <= {w_s2[SLICE-1:0], r_d2};
        r_c3  <= w_s2[SLICE];
        r_a3  <= r_a2[P2-1:SLICE];
        r_b3  <= r_b2[P2-1:SLICE];
        r_sa3 <= r_sa2;
        r_sb3 <= r_sb2;
      end
      if (w_adv4) begin
        r_v4  <= r_v3;
        r_d4  <= {w_s3[SLICE-1:0], r_d3};
        r_c4  <= w_s3[SLICE];
        r_sa4 <= r_sa3;
        r_sb4 <= r_sb3;
      end
    end
  end

  assign in_ready  = w_adv1;
  assign out_valid = r_v4;
  assign diff      = r_d4;
  assign bout      = r_c4;
  assign ovf       = (r_sa4 != r_sb4) && (r_d4[WIDTH-1] != r_sa4);

endmodule

`default_nettype wire

// File: tb/tb_carry_select_subtractor_16bit_pipe.sv
// ---------------------------------------------------------------------------
// tb_carry_select_subtractor_16bit_pipe : directed + random checks with a result scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_carry_select_subtractor_16bit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, bin, out_valid, out_ready, bout, ovf;
  logic [15:0] a, b, diff;

  carry_select_subtractor_16bit_pipe #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } res_t;

  res_t q[$];
  res_t cur_exp;
  int   checks   = 0;
  int   failures = 0;
  logic acc;
  logic prev_stall = 1'b0;

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] f;
    res_t r;
    f    = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    r.d  = f[15:0];
    r.bo = f[16];
    r.ov = (x[15] != y[15]) && (r.d[15] != x[15]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes just before the edge, then step to 1ns past it.
  task automatic tick();
    res_t e;
    #2;
    if (prev_stall) chk("hold_valid", {31'd0, out_valid}, 32'd1);
    acc = in_valid && in_ready;
    if (acc) q.push_back(cur_exp);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("diff", {16'd0, diff}, {16'd0, e.d});
        chk("bout", {31'd0, bout}, {31'd0, e.bo});
        chk("ovf",  {31'd0, ovf},  {31'd0, e.ov});
      end
    end
    prev_stall = out_valid && !out_ready;
    @(posedge clk);
    #1;
  endtask

  // Single isolated op; latency counts edges including the acceptance edge.
  task automatic send_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic bi, input logic [15:0] ed, input logic ebo, input logic eov);
    int lat;
    a = x; b = y; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    cur_exp = '{d: ed, bo: ebo, ov: eov};
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    chk({tag, "_accepted"}, {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd4);
    tick();
    chk({tag, "_drained"}, q.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] ovm;
    logic [11:0] irm;
    int          sent;
    int          cyc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 16'h0; b = 16'h0; bin = 1'b0; cur_exp = '0;
    #11;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff",      {16'd0, diff},      32'd0);
    chk("rst_bout",      {31'd0, bout},      32'd0);
    chk("rst_ovf",       {31'd0, ovf},       32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send_one("basic0",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send_one("basic1",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send_one("basic2",  16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send_one("ripple0", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    send_one("ripple1", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

    // Back-to-back: 8 ops, results visible on 8 consecutive cycles.
    ovm = '0;
    out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      if (t < 8) begin
        in_valid = 1'b1;
        a = 16'h1111 * t[15:0] + 16'h0302;
        b = 16'h0F0F ^ {t[7:0], t[7:0]};
        bin = t[0];
        cur_exp = model(a, b, bin);
        #1;
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
        #1;
      end
      ovm[t] = out_valid;
      tick();
    end
    chk("b2b_valid_pattern", {16'd0, ovm}, 32'h0FF0);
    chk("b2b_drained", q.size(), 32'd0);

    // Backpressure: out_ready low for cycles 3..9 while streaming 6 ops.
    sent = 0;
    irm  = '0;
    for (int t = 0; t < 25; t++) begin
      out_ready = !(t >= 3 && t <= 9);
      in_valid  = (sent < 6);
      a   = 16'hA000 + 16'(sent * 16'h0131);
      b   = 16'h0F37 + 16'(sent * 16'h1002);
      bin = sent[1];
      cur_exp = model(a, b, bin);
      #1;
      if (t < 12) irm[t] = in_ready;
      if (t >= 4 && t <= 9) begin
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        if (q.size() > 0) chk("stall_diff", {16'd0, diff}, {16'd0, q[0].d});
      end
      tick();
      if (acc) sent++;
    end
    chk("bp_in_ready_pattern", {20'd0, irm}, 32'hC0F);
    chk("bp_sent", sent, 32'd6);
    chk("bp_drained", q.size(), 32'd0);

    // Reset with three ops in flight, one of them parked at the output.
    out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      a = 16'h4321 + 16'(t); b = 16'h0101; bin = 1'b0;
      cur_exp = model(a, b, bin);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_diff",      {16'd0, diff},      32'd0);
    chk("midrst_bout",      {31'd0, bout},      32'd0);
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    q.delete();
    prev_stall = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
      tick();
    end
    send_one("post_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Random traffic with random backpressure.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a   = 16'($urandom);
      b   = 16'($urandom);
      bin = 1'($urandom_range(0, 1));
      cur_exp = model(a, b, bin);
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() > 0; t++) tick();
    chk("rand_sent", sent, 32'd10000);
    chk("rand_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
